// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types.
// Word, L1 line bus and the L1-to-L2 arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] pmem_L1_bus;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        MASTER_I,
        MASTER_D
    } arb_master_t;

endpackage

// File: rtl/l1_arbiter.sv
// Arbitrates icache and dcache line traffic onto a single L2 port.
// Ties alternate between masters; each transfer ends with one release cycle.
module l1_arbiter
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,

    input  logic       i_pmem_read,
    input  lc3b_word   i_pmem_address,
    output logic       i_pmem_resp,
    output pmem_L1_bus i_pmem_rdata,

    input  logic       d_pmem_read,
    input  logic       d_pmem_write,
    input  lc3b_word   d_pmem_address,
    input  pmem_L1_bus d_pmem_wdata,
    output logic       d_pmem_resp,
    output pmem_L1_bus d_pmem_rdata,

    output logic       l2_read,
    output logic       l2_write,
    output lc3b_word   l2_address,
    output pmem_L1_bus l2_wdata,
    input  pmem_L1_bus l2_rdata,
    input  logic       l2_resp
);

    arb_state_t  state;
    arb_state_t  next_state;
    arb_master_t last_grant;

    logic d_req;

    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= MASTER_I;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT_I)
                last_grant <= MASTER_I;
            if (state == IDLE && next_state == GRANT_D)
                last_grant <= MASTER_D;
        end
    end

    // The grant is held until l2_resp even if the master drops its request.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_req && i_pmem_read)
                    next_state = (last_grant == MASTER_I) ? GRANT_D : GRANT_I;
                else if (d_req)
                    next_state = GRANT_D;
                else if (i_pmem_read)
                    next_state = GRANT_I;
            end
            GRANT_I: if (l2_resp) next_state = RELEASE;
            GRANT_D: if (l2_resp) next_state = RELEASE;
            RELEASE: next_state = IDLE;
        endcase
    end

    always_comb begin
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;
        i_pmem_rdata = l2_rdata;
        d_pmem_rdata = l2_rdata;
        // Outputs are forced low for the whole reset cycle, not just after it.
        if (rst_n) begin
            unique case (state)
                GRANT_I: begin
                    l2_read     = i_pmem_read;
                    l2_address  = i_pmem_address;
                    i_pmem_resp = l2_resp;
                end
                GRANT_D: begin
                    l2_read     = d_pmem_read & ~d_pmem_write;
                    l2_write    = d_pmem_write;
                    l2_address  = d_pmem_address;
                    l2_wdata    = d_pmem_wdata;
                    d_pmem_resp = l2_resp;
                end
                IDLE, RELEASE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_arbiter.sv
// Directed self-checking bench for l1_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_l1_arbiter;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_pmem_read;
    lc3b_word   i_pmem_address;
    logic       i_pmem_resp;
    pmem_L1_bus i_pmem_rdata;
    logic       d_pmem_read;
    logic       d_pmem_write;
    lc3b_word   d_pmem_address;
    pmem_L1_bus d_pmem_wdata;
    logic       d_pmem_resp;
    pmem_L1_bus d_pmem_rdata;
    logic       l2_read;
    logic       l2_write;
    lc3b_word   l2_address;
    pmem_L1_bus l2_wdata;
    pmem_L1_bus l2_rdata;
    logic       l2_resp;

    int errors = 0;
    int checks = 0;

    localparam pmem_L1_bus RD_LINE = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam pmem_L1_bus WR_LINE = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam pmem_L1_bus I_LINE  = 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678;

    l1_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_address     (l2_address),
        .l2_wdata       (l2_wdata),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " l2_read"}, 128'(l2_read), 128'(0));
        chk({tag, " l2_write"}, 128'(l2_write), 128'(0));
        chk({tag, " l2_address"}, 128'(l2_address), 128'(0));
        chk({tag, " l2_wdata"}, l2_wdata, 128'(0));
        chk({tag, " i_resp"}, 128'(i_pmem_resp), 128'(0));
        chk({tag, " d_resp"}, 128'(d_pmem_resp), 128'(0));
    endtask

    initial begin
        rst_n          = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        l2_rdata       = '0;
        l2_resp        = 1'b0;

        cyc();
        cyc();
        #1 chk_quiet("reset");
        rst_n = 1'b1;

        // Single dcache read, L2 answers in the 4th grant cycle
        cyc();
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h1230;
        #1 chk("rd seen not granted", 128'(l2_read), 128'(0));
        cyc();
        #1 chk("rd g1 l2_read", 128'(l2_read), 128'(1));
        chk("rd g1 addr", 128'(l2_address), 128'(16'h1230));
        chk("rd g1 l2_write", 128'(l2_write), 128'(0));
        chk("rd g1 d_resp", 128'(d_pmem_resp), 128'(0));
        cyc();
        #1 chk("rd g2 l2_read", 128'(l2_read), 128'(1));
        cyc();
        #1 chk("rd g3 l2_read", 128'(l2_read), 128'(1));
        cyc();
        l2_resp  = 1'b1;
        l2_rdata = RD_LINE;
        #1 chk("rd g4 l2_read", 128'(l2_read), 128'(1));
        chk("rd d_resp", 128'(d_pmem_resp), 128'(1));
        chk("rd d_rdata", d_pmem_rdata, RD_LINE);
        chk("rd i_resp", 128'(i_pmem_resp), 128'(0));
        cyc();
        l2_resp     = 1'b0;
        d_pmem_read = 1'b0;
        #1 chk_quiet("rd release");
        cyc();
        #1 chk_quiet("rd idle");

        // Fresh tie after reset goes to dcache, then icache
        rst_n = 1'b0;
        cyc();
        rst_n          = 1'b1;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h2000;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h3000;
        cyc();
        #1 chk("tie first addr", 128'(l2_address), 128'(16'h2000));
        chk("tie first read", 128'(l2_read), 128'(1));
        l2_resp  = 1'b1;
        l2_rdata = RD_LINE;
        #1 chk("tie d_resp", 128'(d_pmem_resp), 128'(1));
        chk("tie i_resp held 0", 128'(i_pmem_resp), 128'(0));
        cyc();
        l2_resp     = 1'b0;
        d_pmem_read = 1'b0;
        #1 chk("tie release read", 128'(l2_read), 128'(0));
        cyc();
        #1 chk("tie idle read", 128'(l2_read), 128'(0));
        cyc();
        #1 chk("tie second addr", 128'(l2_address), 128'(16'h3000));
        chk("tie second read", 128'(l2_read), 128'(1));
        l2_resp  = 1'b1;
        l2_rdata = I_LINE;
        #1 chk("tie i_resp", 128'(i_pmem_resp), 128'(1));
        chk("tie i_rdata", i_pmem_rdata, I_LINE);
        chk("tie d_resp held 0", 128'(d_pmem_resp), 128'(0));
        cyc();
        l2_resp     = 1'b0;
        i_pmem_read = 1'b0;
        cyc();

        // dcache write-back with read also raised: write wins
        d_pmem_write   = 1'b1;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h4440;
        d_pmem_wdata   = WR_LINE;
        cyc();
        #1 chk("wr l2_write", 128'(l2_write), 128'(1));
        chk("wr l2_read", 128'(l2_read), 128'(0));
        chk("wr addr", 128'(l2_address), 128'(16'h4440));
        chk("wr wdata", l2_wdata, WR_LINE);
        chk("wr d_resp early", 128'(d_pmem_resp), 128'(0));
        l2_resp = 1'b1;
        #1 chk("wr d_resp", 128'(d_pmem_resp), 128'(1));
        cyc();
        l2_resp      = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_read  = 1'b0;
        #1 chk_quiet("wr release");
        cyc();

        // Continuous contention: D,I,D,I,D,I after reset
        rst_n = 1'b0;
        cyc();
        rst_n          = 1'b1;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h5550;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h6660;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1 chk($sformatf("alt%0d addr", k), 128'(l2_address),
                   128'((k % 2 == 0) ? 16'h5550 : 16'h6660));
            chk($sformatf("alt%0d read", k), 128'(l2_read), 128'(1));
            l2_resp = 1'b1;
            #1 chk($sformatf("alt%0d d_resp", k), 128'(d_pmem_resp),
                   128'((k % 2 == 0) ? 1 : 0));
            chk($sformatf("alt%0d i_resp", k), 128'(i_pmem_resp),
                128'((k % 2 == 0) ? 0 : 1));
            cyc();
            l2_resp = 1'b0;
            #1 chk($sformatf("alt%0d release", k), 128'(l2_read), 128'(0));
            cyc();
            #1 chk($sformatf("alt%0d idle", k), 128'(l2_read), 128'(0));
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        cyc();

        // Reset during GRANT_I abandons the transfer
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h7770;
        cyc();
        #1 chk("rst gi addr", 128'(l2_address), 128'(16'h7770));
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h8880;
        rst_n          = 1'b0;
        #1 chk_quiet("rst in grant");
        cyc();
        #1 chk_quiet("rst held");
        rst_n = 1'b1;
        #1 chk_quiet("rst idle");
        cyc();
        #1 chk("rst regrant addr", 128'(l2_address), 128'(16'h8880));
        chk("rst regrant read", 128'(l2_read), 128'(1));
        l2_resp = 1'b1;
        #1 chk("rst regrant d_resp", 128'(d_pmem_resp), 128'(1));
        cyc();
        l2_resp     = 1'b0;
        d_pmem_read = 1'b0;
        i_pmem_read = 1'b0;
        cyc();

        // Spurious L2 response in IDLE is dropped
        l2_resp = 1'b1;
        #1 chk_quiet("spurious");
        cyc();
        l2_resp        = 1'b0;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h9990;
        #1 chk("spurious still idle", 128'(l2_read), 128'(0));
        cyc();
        #1 chk("spurious then grant", 128'(l2_address), 128'(16'h9990));
        d_pmem_read = 1'b0;
        l2_resp     = 1'b1;
        cyc();
        l2_resp = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
